// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM command-bus arbiter: command encodings,
// arbiter states and default bus widths.
package sdram_pkg;

  localparam int SDRAM_DATA_W = 16;
  localparam int SDRAM_ADDR_W = 13;
  localparam int SDRAM_BA_W   = 2;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP      = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE   = 4'b0011;
  localparam logic [3:0] CMD_READ     = 4'b0101;
  localparam logic [3:0] CMD_WRITE    = 4'b0100;
  localparam logic [3:0] CMD_B_STOP   = 4'b0110;
  localparam logic [3:0] CMD_P_CHARGE = 4'b0010;
  localparam logic [3:0] CMD_AREF     = 4'b0001;
  localparam logic [3:0] CMD_MREG     = 4'b0000;

  typedef enum logic [2:0] {
    ARB_INIT  = 3'd0,
    ARB_IDLE  = 3'd1,
    ARB_AREF  = 3'd2,
    ARB_WRITE = 3'd3,
    ARB_READ  = 3'd4
  } arb_state_t;

  typedef enum logic {
    GRANT_WRITE = 1'b0,
    GRANT_READ  = 1'b1
  } grant_t;

endpackage

// File: rtl/sdram_cmd_mux.sv
// Selects the granted sub-controller's {cmd, ba, addr} onto the SDRAM pins;
// the idle state parks the bus on NOP with all-ones bank/address.
module sdram_cmd_mux
  import sdram_pkg::*;
#(
  parameter int ADDR_W = SDRAM_ADDR_W,
  parameter int BA_W   = SDRAM_BA_W
) (
  input  arb_state_t        state,
  input  logic [3:0]        init_cmd,
  input  logic [BA_W-1:0]   init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [3:0]        aref_cmd,
  input  logic [BA_W-1:0]   aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic [3:0]        wr_cmd,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [3:0]        rd_cmd,
  input  logic [BA_W-1:0]   rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              cs_n,
  output logic              ras_n,
  output logic              cas_n,
  output logic              we_n,
  output logic [BA_W-1:0]   ba,
  output logic [ADDR_W-1:0] addr
);

  logic [3:0] cmd;

  always_comb begin
    cmd  = CMD_NOP;
    ba   = '1;
    addr = '1;
    case (state)
      ARB_INIT:  begin cmd = init_cmd; ba = init_ba; addr = init_addr; end
      ARB_AREF:  begin cmd = aref_cmd; ba = aref_ba; addr = aref_addr; end
      ARB_WRITE: begin cmd = wr_cmd;   ba = wr_ba;   addr = wr_addr;   end
      ARB_READ:  begin cmd = rd_cmd;   ba = rd_ba;   addr = rd_addr;   end
      default:   ;
    endcase
  end

  assign {cs_n, ras_n, cas_n, we_n} = cmd;

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter: grants init/refresh/write/read one at a time,
// alternates write/read on contention and aborts grants that never end.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int         DATA_W      = SDRAM_DATA_W,
  parameter int         ADDR_W      = SDRAM_ADDR_W,
  parameter int         BA_W        = SDRAM_BA_W,
  parameter logic [9:0] TIMEOUT_CLK = 10'd1000
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [BA_W-1:0]   init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [BA_W-1:0]   aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_sdram_en,
  input  logic [DATA_W-1:0] wr_sdram_data,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [BA_W-1:0]   rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] dq_out,
  output logic              dq_oe,
  output logic              err_timeout
);

  arb_state_t state, state_nxt;
  grant_t     last_grant, last_nxt;
  logic [9:0] cnt;
  logic       timeout, err_set, granted;

  assign timeout = (cnt == TIMEOUT_CLK - 10'd1);
  assign granted = (state == ARB_AREF) || (state == ARB_WRITE) || (state == ARB_READ);

  // A *_end arriving on the timeout cycle counts as a normal end, so no error.
  always_comb begin
    state_nxt = state;
    last_nxt  = last_grant;
    err_set   = 1'b0;
    case (state)
      ARB_INIT: if (init_end) state_nxt = ARB_IDLE;
      ARB_IDLE: begin
        if (aref_req)              state_nxt = ARB_AREF;
        else if (wr_req && rd_req) state_nxt = (last_grant == GRANT_READ) ? ARB_WRITE : ARB_READ;
        else if (wr_req)           state_nxt = ARB_WRITE;
        else if (rd_req)           state_nxt = ARB_READ;
      end
      ARB_AREF: if (aref_end || timeout) begin
        state_nxt = ARB_IDLE;
        err_set   = !aref_end;
      end
      ARB_WRITE: if (wr_end || timeout) begin
        state_nxt = ARB_IDLE;
        last_nxt  = GRANT_WRITE;
        err_set   = !wr_end;
      end
      ARB_READ: if (rd_end || timeout) begin
        state_nxt = ARB_IDLE;
        last_nxt  = GRANT_READ;
        err_set   = !rd_end;
      end
      default: state_nxt = ARB_INIT;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= ARB_INIT;
      last_grant  <= GRANT_READ;
      cnt         <= '0;
      err_timeout <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_nxt;
      if (state_nxt != state) cnt <= '0;
      else if (granted)       cnt <= cnt + 10'd1;
      if (err_set) err_timeout <= 1'b1;
    end
  end

  assign aref_en   = (state == ARB_AREF);
  assign wr_en     = (state == ARB_WRITE);
  assign rd_en     = (state == ARB_READ);
  assign sdram_cke = 1'b1;
  assign dq_out    = wr_sdram_data;
  assign dq_oe     = wr_sdram_en && (state == ARB_WRITE);

  sdram_cmd_mux #(
    .ADDR_W (ADDR_W),
    .BA_W   (BA_W)
  ) u_cmd_mux (
    .state     (state),
    .init_cmd  (init_cmd),
    .init_ba   (init_ba),
    .init_addr (init_addr),
    .aref_cmd  (aref_cmd),
    .aref_ba   (aref_ba),
    .aref_addr (aref_addr),
    .wr_cmd    (wr_cmd),
    .wr_ba     (wr_ba),
    .wr_addr   (wr_addr),
    .rd_cmd    (rd_cmd),
    .rd_ba     (rd_ba),
    .rd_addr   (rd_addr),
    .cs_n      (sdram_cs_n),
    .ras_n     (sdram_ras_n),
    .cas_n     (sdram_cas_n),
    .we_n      (sdram_we_n),
    .ba        (sdram_ba),
    .addr      (sdram_addr)
  );

endmodule

// File: doc/sdram_arbit.md
Name: sdram_arbit

Overview:
- Command-bus arbiter and sequencer for the single SDRAM device.
- Shares the device between four sub-controllers: power-up init, auto-refresh, burst write and burst read.
- Grants one sub-controller at a time and asserts its enable. Muxes that controller's {cmd, ba, addr} onto the SDRAM pins, and drives the DQ output/enable for writes.
- Sits between the sub-controllers and the top-level SDRAM pins.

Parameters:
- DATA_W, 16, SDRAM DQ width.
- ADDR_W, 13, SDRAM address width (A12-A0).
- BA_W, 2, bank address width.
- TIMEOUT_CLK, 10'd1000, max cycles a grant may stay open without its *_end pulse.

Ports:
- sys_clk  in  1  system clock, 100 MHz.
- sys_rst  in  1  asynchronous, active-high reset.
- init_end  in  1  init sequence finished (level, stays high).
- init_cmd  in  4  init {cs_n,ras_n,cas_n,we_n}.
- init_ba  in  BA_W  init bank address.
- init_addr  in  ADDR_W  init address.
- aref_req  in  1  refresh request (level, held until served).
- aref_end  in  1  refresh done (1-cycle pulse).
- aref_cmd / aref_ba / aref_addr  in  4 / BA_W / ADDR_W  refresh bus.
- wr_req  in  1  write request (level).
- wr_end  in  1  write burst done (pulse).
- wr_cmd / wr_ba / wr_addr  in  4 / BA_W / ADDR_W  write bus.
- wr_sdram_en  in  1  write controller drives DQ.
- wr_sdram_data  in  DATA_W  write data.
- rd_req  in  1  read request (level).
- rd_end  in  1  read burst done (pulse).
- rd_cmd / rd_ba / rd_addr  in  4 / BA_W / ADDR_W  read bus.
- aref_en  out  1  refresh grant.
- wr_en  out  1  write grant.
- rd_en  out  1  read grant.
- sdram_cke  out  1  clock enable.
- sdram_cs_n / sdram_ras_n / sdram_cas_n / sdram_we_n  out  1 each  command pins.
- sdram_ba  out  BA_W  bank pins.
- sdram_addr  out  ADDR_W  address pins.
- dq_out  out  DATA_W  DQ drive value.
- dq_oe  out  1  DQ output enable.
- err_timeout  out  1  sticky grant-timeout flag.

Behaviour:
- Reset (sys_rst=1, async):
  - state=ARB_INIT, cnt=0, last_grant=READ.
  - aref_en=wr_en=rd_en=0, dq_oe=0, err_timeout=0, sdram_cke=1.
- States, registered:
  - ARB_INIT -> ARB_IDLE when init_end=1.
  - ARB_IDLE arbitrates in priority order:
    - aref_req -> ARB_AREF.
    - else wr_req & rd_req -> the one not equal to last_grant.
    - else wr_req -> ARB_WRITE.
    - else rd_req -> ARB_READ.
    - else stay.
  - ARB_AREF -> ARB_IDLE on aref_end.
  - ARB_WRITE -> ARB_IDLE on wr_end; set last_grant=WRITE.
  - ARB_READ -> ARB_IDLE on rd_end; set last_grant=READ.
- No preemption: refresh waits for the open write/read to end. Minimum one ARB_IDLE cycle between grants.
- Enables are decoded from state:
  - aref_en=(state==ARB_AREF), wr_en=(state==ARB_WRITE), rd_en=(state==ARB_READ).
  - The enable therefore drops the cycle after *_end, so a sub-controller returning to idle does not restart.
- Command mux, combinational from state:
  - ARB_INIT: init bus.
  - ARB_AREF: aref bus.
  - ARB_WRITE: wr bus.
  - ARB_READ: rd bus.
  - ARB_IDLE: NOP 4'b0111, ba all ones, addr all ones.
  - {sdram_cs_n,sdram_ras_n,sdram_cas_n,sdram_we_n} = selected cmd.
- DQ:
  - dq_out = wr_sdram_data always.
  - dq_oe = wr_sdram_en & (state==ARB_WRITE); otherwise 0.
- Timeout counter:
  - Clears on every state change; increments while in AREF/WRITE/READ.
  - At cnt==TIMEOUT_CLK-1 with no *_end: force ARB_IDLE, set err_timeout (sticky until reset), update last_grant as on normal end.
  - A *_end pulse on that same cycle wins: normal end, no error.
- *_end pulses from non-granted controllers are ignored.
- Requests arriving mid-grant are held by the requester and evaluated in the next ARB_IDLE.
- Reset mid-burst: immediate return to ARB_INIT, all enables 0, bus shows init bus.

Decomposition:
- Shared package sdram_pkg: command encodings (NOP, ACTIVE, READ, WRITE, B_STOP, P_CHARGE, AREF, MREG), arbiter state encodings, DATA_W/ADDR_W/BA_W defaults.
- One natural sub-module: sdram_cmd_mux. It is the combinational 4-way bus select plus idle-NOP default and splits cmd into pins. FSM, fairness bit and timeout stay in sdram_arbit.

Test Plan:
- Reset then init_cmd=4'b0010, init_end low 20 cycles -> pins follow init bus, all *_en=0. Raise init_end -> ARB_IDLE next cycle, pins = NOP/2'b11/13'h1fff.
- wr_req=1 alone -> wr_en=1 on the cycle after IDLE. Pins follow wr bus. dq_oe tracks wr_sdram_en with data 16'hA5A5. wr_end pulse -> wr_en=0 next cycle.
- wr_req and rd_req both held high for 3 bursts with last_grant=READ -> grant order WRITE, READ, WRITE.
- aref_req rises during ARB_READ -> rd_en stays 1 until rd_end. Then one IDLE cycle, then aref_en=1 ahead of a pending wr_req.
- rd_req granted, rd_end never pulses -> after TIMEOUT_CLK=1000 cycles rd_en=0, err_timeout=1 and stays 1.
- sys_rst asserted mid-write with dq_oe=1 -> same-cycle (async) wr_en=0, dq_oe=0, state ARB_INIT.
